// File: rtl/wifi_tx_pkg.sv
// Shared types and defaults for the WiFi TX OFDM symbol path.
// State encoding, default geometry and a constant-foldable log2 helper.
package wifi_tx_pkg;

    localparam int SAMPLE_WIDTH_DEF = 12;
    localparam int NFFT_DEF         = 64;
    localparam int CP_LONG_DEF      = 16;
    localparam int CP_SHORT_DEF     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CAPTURE,
        ST_CP,
        ST_BODY,
        ST_DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wifi_ifft_symbol_ctrl_if.sv
// Mapper / IFFT-core / TX-front-end signal bundle for the symbol controller.
// master drives the controller inputs (mapper, core, pacing); slave is the controller.
interface wifi_ifft_symbol_ctrl_if
    import wifi_tx_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
);
    logic                    ifft_start;
    logic                    gi_short;
    logic                    last_symbol;
    logic [SAMPLE_WIDTH-1:0] sym_re;
    logic [SAMPLE_WIDTH-1:0] sym_im;
    logic                    valid_in;
    logic                    mapper_ready;
    logic [SAMPLE_WIDTH-1:0] fft_din_re;
    logic [SAMPLE_WIDTH-1:0] fft_din_im;
    logic                    fft_din_valid;
    logic                    fft_din_last;
    logic [SAMPLE_WIDTH-1:0] fft_dout_re;
    logic [SAMPLE_WIDTH-1:0] fft_dout_im;
    logic                    fft_dout_valid;
    logic                    sample_en;
    logic [SAMPLE_WIDTH-1:0] sample_real;
    logic [SAMPLE_WIDTH-1:0] sample_im;
    logic                    valid_out;
    logic                    preample_st;
    logic                    enable;
    logic [7:0]              sym_count;
    logic                    done;
    logic                    overflow;

    modport master (
        output ifft_start, gi_short, last_symbol, sym_re, sym_im, valid_in,
               fft_dout_re, fft_dout_im, fft_dout_valid, sample_en,
        input  mapper_ready, fft_din_re, fft_din_im, fft_din_valid, fft_din_last,
               sample_real, sample_im, valid_out, preample_st, enable,
               sym_count, done, overflow
    );

    modport slave (
        input  ifft_start, gi_short, last_symbol, sym_re, sym_im, valid_in,
               fft_dout_re, fft_dout_im, fft_dout_valid, sample_en,
        output mapper_ready, fft_din_re, fft_din_im, fft_din_valid, fft_din_last,
               sample_real, sample_im, valid_out, preample_st, enable,
               sym_count, done, overflow
    );

endinterface

// File: rtl/wifi_sym_buffer.sv
// Single-port symbol RAM, registered read (1 cycle), no backpressure.
// Caller guarantees write and read never share a cycle.
module wifi_sym_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 24,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)     r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wifi_ifft_symbol_ctrl.sv
// OFDM TX symbol controller: mapper -> IFFT core -> buffer -> CP + body replay.
// fft_din and TX samples are 1-cycle registered; mapper stalls outside LOAD, output paced by sample_en.
module wifi_ifft_symbol_ctrl
    import wifi_tx_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int NFFT         = NFFT_DEF,
    parameter int CP_LONG      = CP_LONG_DEF,
    parameter int CP_SHORT     = CP_SHORT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    wifi_ifft_symbol_ctrl_if.slave bus
);

    localparam int AW = clog2(NFFT);
    localparam int DW = 2 * SAMPLE_WIDTH;
    localparam logic [AW-1:0] LAST_IDX = AW'(NFFT - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [AW-1:0]           r_bin_cnt;
    logic [AW-1:0]           r_cap_cnt;
    logic [AW-1:0]           r_rd_cnt;
    logic [AW-1:0]           r_cp_len;
    logic                    r_last_sym;
    logic [7:0]              r_sym_count;
    logic                    r_overflow;
    logic                    r_preamble;
    logic                    r_valid_out;
    logic                    r_din_vld;
    logic                    r_din_last;
    logic [SAMPLE_WIDTH-1:0] r_din_re;
    logic [SAMPLE_WIDTH-1:0] r_din_im;

    logic                    w_start;
    logic                    w_accept;
    logic                    w_cap_wr;
    logic                    w_rd_en;
    logic                    w_cp_end;
    logic                    w_body_end;
    logic [AW-1:0]           w_rd_addr;
    logic [AW-1:0]           w_ram_addr;
    logic [DW-1:0]           w_rdata;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_cap_wr    = 1'b0;
        w_rd_en     = 1'b0;
        w_cp_end    = 1'b0;
        w_body_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.ifft_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_accept = bus.valid_in;
                if (bus.valid_in && r_bin_cnt == LAST_IDX) w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_cap_wr = bus.fft_dout_valid;
                // A zero-length guard interval goes straight to the body.
                if (bus.fft_dout_valid && r_cap_cnt == LAST_IDX)
                    w_state_nxt = (r_cp_len == '0) ? ST_BODY : ST_CP;
            end
            ST_CP: begin
                w_rd_en  = bus.sample_en;
                w_cp_end = bus.sample_en && (r_rd_cnt == r_cp_len - AW'(1));
                if (w_cp_end) w_state_nxt = ST_BODY;
            end
            ST_BODY: begin
                w_rd_en    = bus.sample_en;
                w_body_end = bus.sample_en && (r_rd_cnt == LAST_IDX);
                if (w_body_end) w_state_nxt = r_last_sym ? ST_DONE : ST_LOAD;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Prefix reads the tail of the symbol: NFFT - cp_len + k, modulo NFFT.
    assign w_rd_addr  = (r_state == ST_CP) ? (r_rd_cnt - r_cp_len) : r_rd_cnt;
    assign w_ram_addr = (r_state == ST_CAPTURE) ? r_cap_cnt : w_rd_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin_cnt   <= '0;
            r_cap_cnt   <= '0;
            r_rd_cnt    <= '0;
            r_cp_len    <= '0;
            r_last_sym  <= 1'b0;
            r_sym_count <= '0;
            r_overflow  <= 1'b0;
            r_preamble  <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            r_preamble  <= w_start;
            r_valid_out <= w_rd_en;
            if (w_start) begin
                r_cp_len    <= bus.gi_short ? AW'(CP_SHORT) : AW'(CP_LONG);
                r_sym_count <= '0;
                r_last_sym  <= 1'b0;
                r_bin_cnt   <= '0;
                r_cap_cnt   <= '0;
                r_rd_cnt    <= '0;
            end
            if (w_start)
                r_overflow <= 1'b0;
            else if (bus.fft_dout_valid && r_state != ST_CAPTURE)
                r_overflow <= 1'b1;
            if (w_accept) begin
                r_bin_cnt  <= r_bin_cnt + AW'(1);
                r_last_sym <= r_last_sym | bus.last_symbol;
            end
            if (w_cap_wr) r_cap_cnt <= r_cap_cnt + AW'(1);
            if (w_rd_en)  r_rd_cnt  <= w_cp_end ? '0 : r_rd_cnt + AW'(1);
            if (w_body_end) begin
                r_sym_count <= r_sym_count + 8'd1;
                if (!r_last_sym) r_last_sym <= 1'b0;
            end
            if (w_body_end && !r_last_sym) r_last_sym <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_din_vld  <= 1'b0;
            r_din_last <= 1'b0;
            r_din_re   <= '0;
            r_din_im   <= '0;
        end else begin
            r_din_vld  <= w_accept;
            r_din_last <= w_accept && (r_bin_cnt == LAST_IDX);
            if (w_accept) begin
                r_din_re <= bus.sym_re;
                r_din_im <= bus.sym_im;
            end
        end
    end

    wifi_sym_buffer #(
        .DEPTH (NFFT),
        .WIDTH (DW),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_cap_wr),
        .i_re    (w_rd_en),
        .i_addr  (w_ram_addr),
        .i_wdata ({bus.fft_dout_re, bus.fft_dout_im}),
        .o_rdata (w_rdata)
    );

    assign bus.mapper_ready  = (r_state == ST_LOAD);
    assign bus.fft_din_re    = r_din_re;
    assign bus.fft_din_im    = r_din_im;
    assign bus.fft_din_valid = r_din_vld;
    assign bus.fft_din_last  = r_din_last;
    assign bus.sample_real   = w_rdata[DW-1:SAMPLE_WIDTH];
    assign bus.sample_im     = w_rdata[SAMPLE_WIDTH-1:0];
    assign bus.valid_out     = r_valid_out;
    assign bus.preample_st   = r_preamble;
    assign bus.enable        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign bus.sym_count     = r_sym_count;
    assign bus.done          = (r_state == ST_DONE);
    assign bus.overflow      = r_overflow;

endmodule

// File: tb/tb_wifi_ifft_symbol_ctrl.sv
// Directed bench for wifi_ifft_symbol_ctrl with hand-derived expected samples.
module tb_wifi_ifft_symbol_ctrl;
    import wifi_tx_pkg::*;

    localparam int SW   = 12;
    localparam int NFFT = 64;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    wifi_ifft_symbol_ctrl_if #(.SAMPLE_WIDTH(SW)) bus ();

    wifi_ifft_symbol_ctrl #(
        .SAMPLE_WIDTH (SW),
        .NFFT         (NFFT),
        .CP_LONG      (16),
        .CP_SHORT     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    function automatic logic [SW-1:0] cap_re(input int s, input int n);
        return SW'(n + 100 * s);
    endfunction

    function automatic logic [SW-1:0] cap_im(input int s, input int n);
        return SW'(3000 - n - 7 * s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_pkt(input bit gi);
        bus.gi_short   = gi;
        bus.ifft_start = 1'b1;
        tick();
        bus.ifft_start = 1'b0;
        chk("start_pulse", {bus.preample_st, bus.enable, bus.mapper_ready, bus.sym_count},
            {1'b1, 1'b1, 1'b1, 8'd0});
    endtask

    task automatic load_sym(input bit last);
        for (int n = 0; n < NFFT; n++) begin
            bus.valid_in    = 1'b1;
            bus.sym_re      = SW'(n);
            bus.sym_im      = SW'(4095 - n);
            bus.last_symbol = last;
            tick();
            chk("fft_din", {bus.fft_din_valid, bus.fft_din_last, bus.fft_din_re, bus.fft_din_im},
                {1'b1, (n == NFFT - 1), SW'(n), SW'(4095 - n)});
        end
        bus.sym_re = SW'(12'hABC);
        chk("ready_fall", {31'd0, bus.mapper_ready}, 32'd0);
        tick();
        chk("late_bin_dropped", {31'd0, bus.fft_din_valid}, 32'd0);
        bus.valid_in    = 1'b0;
        bus.last_symbol = 1'b0;
    endtask

    task automatic capture_sym(input int s, input bit restart);
        for (int n = 0; n < NFFT; n++) begin
            bus.fft_dout_valid = 1'b1;
            bus.fft_dout_re    = cap_re(s, n);
            bus.fft_dout_im    = cap_im(s, n);
            bus.ifft_start     = restart && (n == 5);
            tick();
            bus.ifft_start     = 1'b0;
            if (restart && n == 5)
                chk("restart_ignored", {31'd0, bus.preample_st}, 32'd0);
        end
        bus.fft_dout_valid = 1'b0;
    endtask

    task automatic play(input int cp, input int s, input int nstr, input int period,
                        input bit last, input logic [7:0] exp_cnt);
        for (int i = 0; i < nstr; i++) begin
            int a;
            a = (i < cp) ? (NFFT - cp + i) : (i - cp);
            bus.sample_en = 1'b1;
            tick();
            bus.sample_en = 1'b0;
            chk("sample", {bus.valid_out, bus.sample_real, bus.sample_im},
                {1'b1, cap_re(s, a), cap_im(s, a)});
            if (i == cp + NFFT - 1) begin
                chk("sym_count", {24'd0, bus.sym_count}, {24'd0, exp_cnt});
                if (last)
                    chk("done_edge", {30'd0, bus.done, bus.enable}, {30'd0, 2'b10});
                else
                    chk("ready_again", {30'd0, bus.done, bus.mapper_ready}, {30'd0, 2'b01});
            end
            for (int p = 1; p < period; p++) begin
                tick();
                chk("valid_gap", {31'd0, bus.valid_out}, 32'd0);
            end
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.ifft_start     = 1'b0;
        bus.gi_short       = 1'b0;
        bus.last_symbol    = 1'b0;
        bus.sym_re         = '0;
        bus.sym_im         = '0;
        bus.valid_in       = 1'b0;
        bus.fft_dout_re    = '0;
        bus.fft_dout_im    = '0;
        bus.fft_dout_valid = 1'b0;
        bus.sample_en      = 1'b0;
        repeat (3) tick();
        chk("reset_ctl", {24'd0, bus.mapper_ready, bus.fft_din_valid, bus.fft_din_last, bus.valid_out,
                          bus.preample_st, bus.enable, bus.done, bus.overflow}, 32'd0);
        chk("reset_dat", {bus.fft_din_re, bus.fft_din_im, bus.sym_count}, 32'd0);
        chk("reset_smp", {8'd0, bus.sample_real, bus.sample_im}, 32'd0);
        reset = 1'b0;
        tick();

        // Long GI, single symbol: 48..63 then 0..63.
        start_pkt(1'b0);
        load_sym(1'b1);
        capture_sym(0, 1'b0);
        play(16, 0, 80, 1, 1'b1, 8'd1);
        tick();
        tick();
        chk("pkt_a_end", {30'd0, bus.done, bus.enable}, 32'd0);
        chk("pkt_a_done_cnt", 32'(done_cnt), 32'd1);

        // Short GI, three symbols; middle symbol paced every 4th cycle.
        start_pkt(1'b1);
        for (int s = 0; s < 3; s++) begin
            load_sym(s == 2);
            capture_sym(s, 1'b0);
            play(8, s, 72, (s == 1) ? 4 : 1, (s == 2), 8'(s + 1));
        end
        tick();
        tick();
        chk("pkt_b_done_cnt", 32'(done_cnt), 32'd2);

        // Stray core output during LOAD, plus a restart request during CAPTURE.
        start_pkt(1'b0);
        bus.fft_dout_valid = 1'b1;
        tick();
        bus.fft_dout_valid = 1'b0;
        chk("ovf_set", {31'd0, bus.overflow}, 32'd1);
        load_sym(1'b1);
        capture_sym(3, 1'b1);
        chk("ovf_capture", {24'd0, bus.overflow, bus.sym_count[6:0]}, {24'd0, 1'b1, 7'd0});
        play(16, 3, 80, 1, 1'b1, 8'd1);
        tick();
        tick();
        chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
        chk("pkt_c_done_cnt", 32'(done_cnt), 32'd3);

        // Next packet clears overflow; reset lands mid-BODY of symbol 2.
        start_pkt(1'b0);
        chk("ovf_clear", {31'd0, bus.overflow}, 32'd0);
        load_sym(1'b0);
        capture_sym(4, 1'b0);
        play(16, 4, 80, 1, 1'b0, 8'd1);
        load_sym(1'b1);
        capture_sym(5, 1'b0);
        play(16, 5, 40, 1, 1'b0, 8'd1);
        reset = 1'b1;
        tick();
        chk("abort_ctl", {24'd0, bus.mapper_ready, bus.fft_din_valid, bus.fft_din_last, bus.valid_out,
                          bus.preample_st, bus.enable, bus.done, bus.overflow}, 32'd0);
        chk("abort_dat", {bus.sample_real, bus.sample_im, bus.sym_count}, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("abort_no_done", 32'(done_cnt), 32'd3);

        // Clean packet after abort, short GI, strobe every other cycle.
        start_pkt(1'b1);
        load_sym(1'b1);
        capture_sym(6, 1'b0);
        play(8, 6, 72, 2, 1'b1, 8'd1);
        tick();
        tick();
        chk("pkt_e_done_cnt", 32'(done_cnt), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
